// File: rtl/saratoga_pkg.sv
// Shared CSR addresses, op encoding, bit indices and writable masks for the
// saratoga machine-mode trap CSR file.
package saratoga_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [1:0] MSTATUS_MPP = 2'b11;

    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;
    localparam int IRQ_MEI = 11;

    localparam int MTVEC_ADDR_BIT_ALIGN = 6;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MTVEC_WMASK   = ~((32'h1 << MTVEC_ADDR_BIT_ALIGN) - 32'h1) | 32'h1;
    localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] FULL_WMASK    = 32'hFFFF_FFFF;

    function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old, logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old | wdata;
            CSR_RC:  return old & ~wdata;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/trap_csr_irq_sync.sv
// N-bit two-flop synchroniser for asynchronous interrupt pins; resets to 0.
module irq_sync #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [N-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap CSR file: CSR read/write, trap capture, MRET stack pop.
// Define TRAP_CSR_IRQ_SYNC_EN to pass irq pins through a 2-flop synchroniser.
module trap_csr
    import saratoga_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  csr_op_t     csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_wsuppress,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        csr_ro_fault,
    input  logic        trap_insert,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        irq_external,
    output logic [31:0] interrupts,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);
    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_r, mtvec_r, mscratch, mepc_r, mcause, mtval;
    logic [31:0] mstatus_val, mip_val, wnew;
    logic [2:0]  irq_pins, irq_q;
    logic        ro_addr, do_write;

    assign irq_pins = {irq_external, irq_timer, irq_software};

`ifdef TRAP_CSR_IRQ_SYNC_EN
    irq_sync #(.N(3)) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_pins),
        .q     (irq_q)
    );
`else
    assign irq_q = irq_pins;
`endif

    always_comb begin
        mip_val          = '0;
        mip_val[IRQ_MSI] = irq_q[0];
        mip_val[IRQ_MTI] = irq_q[1];
        mip_val[IRQ_MEI] = irq_q[2];
    end

    assign mstatus_val = {19'b0, MSTATUS_MPP, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_val;
            CSR_MIE:      csr_rdata = mie_r;
            CSR_MTVEC:    csr_rdata = mtvec_r;
            CSR_MSCRATCH: csr_rdata = mscratch;
            CSR_MEPC:     csr_rdata = mepc_r;
            CSR_MCAUSE:   csr_rdata = mcause;
            CSR_MTVAL:    csr_rdata = mtval;
            CSR_MIP:      csr_rdata = mip_val;
            CSR_MHARTID:  csr_rdata = HART_ID;
            default:      csr_hit   = 1'b0;
        endcase
    end

    assign ro_addr      = (csr_addr == CSR_MIP) || (csr_addr == CSR_MHARTID);
    assign csr_ro_fault = csr_en & csr_hit & ro_addr & ~csr_wsuppress & (csr_op != CSR_NONE);
    assign do_write     = csr_en & csr_hit & ~ro_addr & ~csr_wsuppress & (csr_op != CSR_NONE);
    assign wnew         = csr_apply(csr_op, csr_rdata, csr_wdata);

    // trap_insert outranks mret outranks CSR write; writes to untouched regs still land
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_r        <= '0;
            mtvec_r      <= MTVEC_RESET;
            mscratch     <= '0;
            mepc_r       <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else begin
            if (trap_insert) begin
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (do_write && csr_addr == CSR_MSTATUS) begin
                mstatus_mie  <= wnew[MSTATUS_MIE];
                mstatus_mpie <= wnew[MSTATUS_MPIE];
            end

            if (trap_insert) begin
                mepc_r <= trap_epc & MEPC_WMASK;
                mcause <= trap_cause;
                mtval  <= trap_val;
            end else if (do_write) begin
                if (csr_addr == CSR_MEPC)   mepc_r <= wnew & MEPC_WMASK;
                if (csr_addr == CSR_MCAUSE) mcause <= wnew & FULL_WMASK;
                if (csr_addr == CSR_MTVAL)  mtval  <= wnew & FULL_WMASK;
            end

            if (do_write && csr_addr == CSR_MIE)      mie_r    <= wnew & MIE_WMASK;
            if (do_write && csr_addr == CSR_MTVEC)    mtvec_r  <= wnew & MTVEC_WMASK;
            if (do_write && csr_addr == CSR_MSCRATCH) mscratch <= wnew & FULL_WMASK;
        end
    end

    assign interrupts = {32{mstatus_mie}} & mip_val & mie_r;
    assign mtvec      = mtvec_r;
    assign mepc       = mepc_r;
endmodule
